// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: one LCD frame (sign + NUM_DIGITS digits) built from a signed
// BCD reading, with a random-access read port and a valid/ready stream that
// sends a set-cursor command followed by the frame characters on every update.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   upd, neg, bcd   update strobe, negative flag, BCD digits (MS nibble on top)
//   addr, rd_Data   combinational read of the stored frame
//   out_valid, out_data, out_ready   command/character stream to the LCD controller
//   busy, pending   frame in flight, update queued behind it
module lcd_frame_buffer #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned SIZE       = 9,
    parameter int unsigned BASE_ADDR  = 5,
    parameter logic [6:0]  CURSOR_POS = 7'h05,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd,
    input  logic                    neg,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [5:0]              addr,
    output logic [SIZE-1:0]         rd_Data,
    output logic                    out_valid,
    output logic [SIZE-1:0]         out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    pending
);

    localparam int unsigned FRAME_LEN = NUM_DIGITS + 1;
    localparam int unsigned IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned BCD_W     = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS);
    localparam logic [SIZE-1:0]  CH_SPACE   = SIZE'(9'h120);
    localparam logic [SIZE-1:0]  CH_MINUS   = SIZE'(9'h12D);
    localparam logic [SIZE-1:0]  CH_ZERO    = SIZE'(9'h130);
    localparam logic [SIZE-1:0]  CH_QMARK   = SIZE'(9'h13F);
    localparam logic [SIZE-1:0]  CMD_CURSOR = SIZE'({2'b01, CURSOR_POS});
    localparam logic [6:0]       ADDR_LO    = 7'(BASE_ADDR);
    localparam logic [6:0]       ADDR_HI    = 7'(BASE_ADDR + NUM_DIGITS);

    typedef logic [FRAME_LEN-1:0][SIZE-1:0] frame_t;
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, CHAR = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    frame_t             rf_q, rf_d;
    logic [SIZE-1:0]    out_data_q, out_data_d;
    logic               pend_q, pend_d;
    logic               pend_neg_q, pend_neg_d;
    logic [BCD_W-1:0]   pend_bcd_q, pend_bcd_d;

    logic               hs_c;
    logic               last_hs_c;
    logic               start_c;
    logic [6:0]         addr_ext_c;
    logic [IDX_W-1:0]   rd_idx_c;

    // Signed BCD reading -> LCD frame; entry 0 is the sign, then MS digit first.
    function automatic frame_t convert(input logic n, input logic [BCD_W-1:0] b);
        frame_t     f;
        logic       seen;
        logic [3:0] nib;
        seen = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib = b[BCD_W-4-4*i +: 4];
            if (nib != 4'd0) seen = 1'b1;   // illegal nibbles count as nonzero
            if (BLANK_LZ && !seen && (i != NUM_DIGITS - 1))
                f[IDX_W'(i + 1)] = CH_SPACE;
            else if (nib > 4'd9)
                f[IDX_W'(i + 1)] = CH_QMARK;
            else
                f[IDX_W'(i + 1)] = CH_ZERO + SIZE'(nib);
        end
        f[0] = (n && seen) ? CH_MINUS : CH_SPACE;  // -0 shows as space
        return f;
    endfunction

    assign hs_c      = (state_q != IDLE) && out_ready;
    assign last_hs_c = hs_c && (state_q == CHAR) && (idx_q == LAST_IDX);
    // A new frame starts from idle, or back-to-back on the final handshake.
    assign start_c   = ((state_q == IDLE) && upd) || (last_hs_c && (upd || pend_q));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: if (upd) state_d = CMD;
            CMD: begin
                if (hs_c) begin
                    state_d = CHAR;
                    idx_d   = '0;
                end
            end
            CHAR: begin
                if (hs_c) begin
                    if (idx_q == LAST_IDX) state_d = start_c ? CMD : IDLE;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        out_data_d = out_data_q;
        rf_d       = rf_q;
        pend_d     = pend_q;
        pend_neg_d = pend_neg_q;
        pend_bcd_d = pend_bcd_q;

        if (start_c) begin
            // A same-cycle upd is newer than anything queued, so it wins.
            rf_d       = upd ? convert(neg, bcd) : convert(pend_neg_q, pend_bcd_q);
            out_data_d = CMD_CURSOR;
        end else if (hs_c && (state_q == CMD)) begin
            out_data_d = rf_q[0];
        end else if (hs_c && (state_q == CHAR) && (idx_q != LAST_IDX)) begin
            out_data_d = rf_q[idx_q + IDX_W'(1)];
        end

        if (last_hs_c) begin
            pend_d = 1'b0;
        end else if (upd && (state_q != IDLE)) begin
            pend_d     = 1'b1;
            pend_neg_d = neg;
            pend_bcd_d = bcd;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q       <= {FRAME_LEN{CH_SPACE}};
            out_data_q <= '0;
            pend_q     <= 1'b0;
            pend_neg_q <= 1'b0;
            pend_bcd_q <= '0;
        end else begin
            rf_q       <= rf_d;
            out_data_q <= out_data_d;
            pend_q     <= pend_d;
            pend_neg_q <= pend_neg_d;
            pend_bcd_q <= pend_bcd_d;
        end
    end

    // Random-access read port
    assign addr_ext_c = {1'b0, addr};
    assign rd_idx_c   = IDX_W'(addr_ext_c - ADDR_LO);

    always_comb begin
        rd_Data = CH_SPACE;
        if ((addr_ext_c >= ADDR_LO) && (addr_ext_c <= ADDR_HI)) rd_Data = rf_q[rd_idx_c];
    end

    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign pending   = pend_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// Scoreboard bench for lcd_frame_buffer (defaults: 3 digits, base 5, blanking on).
module tb_lcd_frame_buffer;

    localparam int ND   = 3;
    localparam int BASE = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd = 1'b0;
    logic        neg = 1'b0;
    logic [11:0] bcd = '0;
    logic [5:0]  addr = '0;
    logic        out_ready = 1'b0;
    logic [8:0]  rd_Data;
    logic        out_valid;
    logic [8:0]  out_data;
    logic        busy;
    logic        pending;

    lcd_frame_buffer dut (
        .clk(clk), .rst(rst), .upd(upd), .neg(neg), .bcd(bcd), .addr(addr),
        .rd_Data(rd_Data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected word stream, visible frame, queued update.
    logic [8:0]       exp_q[$];
    logic [3:0][8:0]  m_rf = {4{9'h120}};
    bit               m_pend = 1'b0;
    bit               m_pn = 1'b0;
    logic [11:0]      m_pb = '0;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    // Expected display characters from the numeric reading.
    function automatic logic [3:0][8:0] model_frame(input bit n, input logic [11:0] b);
        logic [3:0][8:0] f;
        logic [3:0]      nib;
        int              first_nz;
        first_nz = ND;
        for (int i = 0; i < ND; i++) begin
            nib = b[4*(ND-1-i) +: 4];
            if (nib != 4'd0 && first_nz == ND) first_nz = i;
        end
        for (int i = 0; i < ND; i++) begin
            nib = b[4*(ND-1-i) +: 4];
            if (i < first_nz && i != ND - 1) f[i+1] = 9'h120;
            else if (nib > 4'd9)             f[i+1] = 9'h13F;
            else                             f[i+1] = 9'h130 + 9'(nib);
        end
        f[0] = (n && first_nz != ND) ? 9'h12D : 9'h120;
        return f;
    endfunction

    task automatic push_frame(input bit n, input logic [11:0] b);
        logic [3:0][8:0] f;
        f = model_frame(n, b);
        exp_q.push_back(9'h085);
        for (int i = 0; i <= ND; i++) exp_q.push_back(f[i]);
        m_rf = f;
    endtask

    // Monitor: mid-cycle compare of outputs against the scoreboard, then
    // advance the model with this cycle's handshake and update.
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", 9'(out_valid), 9'(exp_q.size() != 0));
            chk("busy", 9'(busy), 9'(exp_q.size() != 0));
            chk("pending", 9'(pending), 9'(m_pend));
            if (addr >= BASE && addr <= BASE + ND) chk("rd_Data", rd_Data, m_rf[int'(addr) - BASE]);
            else                                   chk("rd_Data_oob", rd_Data, 9'h120);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (upd) begin
                m_pend = 1'b1;
                m_pn   = neg;
                m_pb   = bcd;
            end
            if (exp_q.size() == 0 && m_pend) begin
                push_frame(m_pn, m_pb);
                m_pend = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit n, input logic [11:0] b);
        upd = 1'b1;
        neg = n;
        bcd = b;
        step();
        upd = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !m_pend) break;
            step();
        end
        chk("drain_timeout", 9'(exp_q.size()), 9'd0);
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] b;
        for (int i = 0; i < ND; i++)
            b[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
        return b;
    endfunction

    int  a_list[6] = '{4, 5, 6, 7, 8, 9};
    bit  rdy_pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 9'(out_valid), 9'd0);
        chk("rst_busy", 9'(busy), 9'd0);
        chk("rst_pending", 9'(pending), 9'd0);
        chk("rst_out_data", out_data, 9'd0);
        foreach (a_list[i]) begin
            addr = 6'(a_list[i]);
            #1;
            chk("rst_rd", rd_Data, 9'h120);
        end
        step();
        rst = 1'b1;
        step();

        // Negative two-digit reading, ready held high
        out_ready = 1'b1;
        send(1'b1, 12'h025);
        wait_idle();
        addr = 6'd6;
        #1 chk("rd_at6", rd_Data, 9'h120);
        addr = 6'd8;
        #1 chk("rd_at8", rd_Data, 9'h135);
        step();

        // -0 shows no sign
        send(1'b1, 12'h000);
        wait_idle();

        // Stalls mid-frame plus a queued update
        send(1'b0, 12'h789);
        for (int i = 0; i < 8; i++) begin
            out_ready = rdy_pat[i];
            if (i == 2) begin
                upd = 1'b1;
                neg = 1'b0;
                bcd = 12'h100;
            end
            step();
            upd = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();

        // Illegal nibble
        send(1'b0, 12'h0A3);
        wait_idle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            upd       = ($urandom_range(0, 7) == 0);
            neg       = 1'($urandom_range(0, 1));
            bcd       = rand_bcd();
            addr      = 6'($urandom_range(0, 12));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        upd = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset while a word is being presented
        out_ready = 1'b0;
        send(1'b1, 12'h456);
        step();
        rst = 1'b0;
        exp_q.delete();
        m_pend = 1'b0;
        m_rf   = {4{9'h120}};
        #1;
        chk("midrst_valid", 9'(out_valid), 9'd0);
        chk("midrst_busy", 9'(busy), 9'd0);
        chk("midrst_pending", 9'(pending), 9'd0);
        for (int a = BASE; a <= BASE + ND; a++) begin
            addr = 6'(a);
            #1 chk("midrst_rd", rd_Data, 9'h120);
        end
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        send(1'b0, 12'h007);
        wait_idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_frame_buffer.md
Name: lcd_frame_buffer

Overview:
- Parametrised successor to the temperature display register file.
- Holds one display frame of a sign position plus NUM_DIGITS digit positions as 9-bit LCD words, converted from a signed BCD reading, with optional leading-zero blanking.
- Keeps the random-access read port used by the LCD sequencer.
- Adds a streaming output: on each update it emits a set-cursor command followed by the frame characters over a valid/ready handshake, with frame coherence and one pending-update slot.

Parameters:
- NUM_DIGITS, 3, number of digit positions (1..8); frame = NUM_DIGITS+1 characters
- SIZE, 9, LCD word width; bit 8 = RS (1 data, 0 command), bits 7:0 = byte
- BASE_ADDR, 5, read-port address of the sign position
- CURSOR_POS, 7'h05, LCD DDRAM address written by the set-cursor command
- BLANK_LZ, 1, 1 = leading zeros shown as space, 0 = shown as '0'

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- upd  in  1  one-cycle strobe: capture neg/bcd as a new frame
- neg  in  1  reading is negative
- bcd  in  4*NUM_DIGITS  BCD digits, most significant nibble at top
- addr  in  6  read-port address
- rd_Data  out  SIZE  combinational read of stored frame entry
- out_valid  out  1  out_data holds a word for the LCD controller
- out_data  out  SIZE  command/character word
- out_ready  in  1  LCD controller accepts word when high with out_valid
- busy  out  1  frame transmission in progress (state != IDLE)
- pending  out  1  an update is queued behind the current frame

Behaviour:
- Encoding:
  - space = 9'h120; '-' = 9'h12D; digit d (0..9) = 9'h130+d.
  - Illegal nibble (>9) = '?' 9'h13F; blanking treats it as nonzero.
  - Set-cursor command = {1'b0, 1'b1, CURSOR_POS}.
- Storage: rf[0] = sign; rf[1..NUM_DIGITS] = digits, most significant first.
- Reset: asynchronous on rst low. All rf entries = 9'h120; out_valid = 0; out_data = 0; busy = 0; pending = 0; state = IDLE. A reset mid-frame aborts the frame immediately, with no further handshakes.
- Conversion rules:
  - With BLANK_LZ=1, digits above the most significant nonzero digit become space; the least significant digit is always shown.
  - Sign = '-' only if neg and at least one digit is nonzero, so -0 shows as space; otherwise space.
- Read port:
  - rd_Data = rf[addr-BASE_ADDR] when BASE_ADDR <= addr <= BASE_ADDR+NUM_DIGITS; otherwise 9'h120.
  - Purely combinational from the registered rf.
- FSM states IDLE, CMD, CHAR (index idx 0..NUM_DIGITS):
  - IDLE, upd=1: rf loaded with the converted frame at the edge; next cycle state = CMD, out_valid = 1, out_data = cursor command. Latency upd -> out_valid = 1 cycle.
  - CMD, out_valid & out_ready: go to CHAR with idx = 0; out_data = rf[0].
  - CHAR, handshake with idx < NUM_DIGITS: idx+1; out_data = rf[idx+1].
  - CHAR, handshake with idx = NUM_DIGITS and pending=0: state = IDLE, out_valid = 0.
  - CHAR, handshake with idx = NUM_DIGITS and pending=1: rf loaded from the pending capture, pending cleared, state = CMD. out_valid stays 1 with no gap.
- Handshake rules:
  - While out_valid & !out_ready, out_data and state hold stable.
  - out_valid never drops without a handshake, except on reset.
- Frame coherence: rf is never written while busy. upd while busy captures neg/bcd into a pending register and sets pending; a further upd overwrites it, so the latest update wins.
- upd in the same cycle as the final handshake: captured as pending and started immediately, i.e. treated as busy.
- A new frame always re-sends the full frame even if the data is unchanged.

Test Plan:
- Reset, then read addr 5..8 and 4, 9 -> all 9'h120; out_valid=0, busy=0.
- upd neg=1 bcd=12'h025, out_ready=1 -> from the next cycle out_data sequence 9'h085, 9'h12D, 9'h120, 9'h132, 9'h135 on consecutive cycles, then out_valid=0. rd_Data@6=9'h120, @8=9'h135.
- upd neg=1 bcd=12'h000 -> sign 9'h120, digits 9'h120, 9'h120, 9'h130 (no -0). With BLANK_LZ=0 the digits are 9'h130 ×3.
- out_ready toggled 1-0-0-1 mid-frame -> out_data held during the stall cycles. A second upd (bcd=12'h100) mid-frame -> pending=1, rf unchanged until the last handshake, then cursor command follows with no out_valid gap and the frame is 9'h120, 9'h131, 9'h130, 9'h130.
- Illegal nibble bcd=12'h0A3 -> digits 9'h120, 9'h13F, 9'h133.
- rst low while out_valid=1 -> out_valid=0, busy=0, pending=0 in the same cycle, and all entries 9'h120.
